// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receive control slice.
package uart_rx_pkg;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int NUM_BITS_DEF     = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SAMPLE,
    STOP_CHK,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: counts to a half- or full-bit terminal value and tallies
// terminal counts in bit_cnt.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              enable,
  input  logic                              half,
  output logic                              tc,
  output logic [$clog2(NUM_BITS+1)-1:0]     bit_cnt
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] timer;
  logic [TW-1:0] term;

  // Half period centres sampling in the start bit; full period thereafter.
  assign term = half ? TW'(CLKS_PER_BIT/2 - 1) : TW'(CLKS_PER_BIT - 1);
  assign tc   = enable && (timer == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (enable) begin
      timer <= tc ? '0 : timer + 1'b1;
      if (tc) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-bit detection, bit timing, shift strobes,
// stop-bit check, buffer load and reader status flags.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_BITS     = NUM_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int CW = $clog2(NUM_BITS + 1);

  rx_state_t state, next_state;
  logic          prev_in;
  logic          fall;
  logic          timer_clear;
  logic          timer_en;
  logic          half;
  logic          tc;
  logic [CW-1:0] bit_cnt;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .NUM_BITS     (NUM_BITS)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .half    (half),
    .tc      (tc),
    .bit_cnt (bit_cnt)
  );

  assign fall = prev_in && !serial_in;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prev_in <= 1'b1;
    end else begin
      state   <= next_state;
      prev_in <= serial_in;
    end
  end

  always_comb begin
    next_state   = state;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    half         = 1'b0;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          next_state  = START;
          timer_clear = 1'b1;
        end
      end
      START: begin
        timer_en = 1'b1;
        half     = 1'b1;
        // A line that is high again at mid start bit was only a glitch.
        if (tc) begin
          if (!serial_in) begin
            next_state  = SAMPLE;
            timer_clear = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      SAMPLE: begin
        timer_en = 1'b1;
        if (tc) begin
          shift_strobe = 1'b1;
          if (bit_cnt == CW'(NUM_BITS - 1)) begin
            next_state = STOP_CHK;
          end
        end
      end
      STOP_CHK: begin
        next_state = stop_bit ? LOAD : IDLE;
      end
      LOAD: begin
        load_buffer = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A load in the same cycle as a read wins: the fresh byte stays ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state == LOAD) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) begin
          overrun_error <= 1'b1;
        end else if (data_read) begin
          overrun_error <= 1'b0;
        end
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (state == IDLE && fall) begin
        framing_error <= 1'b0;
      end else if (state == STOP_CHK && !stop_bit) begin
        framing_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with default parameters.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic stop_bit;
  logic data_read;
  logic shift_strobe;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;
  logic busy;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .stop_bit      (stop_bit),
    .data_read     (data_read),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  // Receive shift register in the environment, clocked by the DUT's strobes.
  logic [8:0] sr = 9'h1FF;
  always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
  assign stop_bit = sr[8];

  int cyc = 0;
  int strobe_q[$];
  int load_cnt = 0;
  always @(negedge clk) begin
    if (shift_strobe) strobe_q.push_back(cyc);
    if (load_buffer) load_cnt = load_cnt + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] line_bits;
  int line_base = 0;
  bit line_active = 1'b0;
  int e_cyc = 0;

  // Expected outputs packed as {shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy}.
  typedef struct {
    string      name;
    int         off;
    logic       rd;
    logic [5:0] exp;
  } vec_t;

  vec_t clean_tbl[11];

  function automatic logic [5:0] outs();
    return {shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy};
  endfunction

  task automatic tick();
    int off;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    data_read = 1'b0;
    if (line_active) begin
      off = cyc - line_base;
      if (off >= 100) begin
        serial_in = 1'b1;
        line_active = 1'b0;
      end else begin
        serial_in = line_bits[off / 10];
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %b, expected %b (strobe,load,ready,ferr,ovr,busy) at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycle(input int target);
    if (cyc > target) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL schedule: at cycle %0d, expected to reach %0d", cyc, target);
    end
    while (cyc < target) tick();
  endtask

  // Line goes low in the next cycle, so the first START cycle is two ahead.
  task automatic begin_frame(input logic [7:0] data, input logic stop);
    line_bits = {stop, data, 1'b0};
    line_base = cyc + 1;
    line_active = 1'b1;
    e_cyc = cyc + 2;
    strobe_q.delete();
    load_cnt = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wait_cycle(e_cyc + v.off);
    data_read = v.rd;
    checkOutput(v.name, outs(), v.exp);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] data);
    checkInt({tag, "_strobe_count"}, strobe_q.size(), 9);
    for (int n = 0; n < 9; n++) begin
      if (n < strobe_q.size())
        checkInt($sformatf("%s_strobe%0d_pos", tag, n + 1), strobe_q[n] - e_cyc, 14 + 10 * n);
    end
    checkInt({tag, "_data"}, int'(sr[7:0]), int'(data));
  endtask

  task automatic run_clean(input string tag, input logic [7:0] data);
    begin_frame(data, 1'b1);
    for (int i = 0; i < 11; i++) applyStimulus(clean_tbl[i]);
    check_frame(tag, data);
  endtask

  initial begin
    int g_e;
    clean_tbl = '{
      '{"start_e0",    0, 1'b0, 6'b000001},
      '{"start_e4",    4, 1'b0, 6'b000001},
      '{"sample_e5",   5, 1'b0, 6'b000001},
      '{"pre_strobe1", 13, 1'b0, 6'b000001},
      '{"strobe1",    14, 1'b0, 6'b100001},
      '{"post_strobe1",15, 1'b0, 6'b000001},
      '{"strobe2",    24, 1'b0, 6'b100001},
      '{"strobe9",    94, 1'b0, 6'b100001},
      '{"stop_chk",   95, 1'b0, 6'b000001},
      '{"load",       96, 1'b0, 6'b010001},
      '{"ready",      97, 1'b0, 6'b001000}
    };

    rst = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_outputs", outs(), 6'b000000);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("after_reset_idle", outs(), 6'b000000);

    $display("[TB] clean frame 0xA5");
    run_clean("clean", 8'hA5);
    tick();
    data_read = 1'b1;
    tick();
    checkOutput("read_clears_ready", outs(), 6'b000000);

    $display("[TB] glitch");
    repeat (5) tick();
    strobe_q.delete();
    serial_in = 1'b0;
    g_e = cyc + 1;
    tick();
    tick();
    tick();
    serial_in = 1'b1;
    wait_cycle(g_e + 4);
    checkOutput("glitch_start_end", outs(), 6'b000001);
    wait_cycle(g_e + 5);
    checkOutput("glitch_back_idle", outs(), 6'b000000);
    wait_cycle(g_e + 30);
    checkInt("glitch_no_strobes", strobe_q.size(), 0);

    $display("[TB] framing error");
    begin_frame(8'hA5, 1'b0);
    wait_cycle(e_cyc + 95);
    checkOutput("ferr_stop_chk", outs(), 6'b000001);
    wait_cycle(e_cyc + 96);
    checkOutput("ferr_set", outs(), 6'b000100);
    wait_cycle(e_cyc + 110);
    checkInt("ferr_no_load", load_cnt, 0);
    checkOutput("ferr_holds", outs(), 6'b000100);

    $display("[TB] overrun");
    begin_frame(8'h3C, 1'b1);
    wait_cycle(e_cyc);
    checkOutput("ferr_cleared_by_edge", outs(), 6'b000001);
    wait_cycle(e_cyc + 97);
    checkOutput("ovr_first_ready", outs(), 6'b001000);
    check_frame("ovr1", 8'h3C);
    repeat (4) tick();
    begin_frame(8'hC3, 1'b1);
    wait_cycle(e_cyc + 96);
    checkOutput("ovr_second_load", outs(), 6'b011001);
    wait_cycle(e_cyc + 97);
    checkOutput("ovr_set", outs(), 6'b001010);
    check_frame("ovr2", 8'hC3);
    data_read = 1'b1;
    tick();
    checkOutput("ovr_read_clears", outs(), 6'b000000);

    $display("[TB] back-to-back with read during load");
    repeat (3) tick();
    begin_frame(8'h5A, 1'b1);
    wait_cycle(e_cyc + 96);
    checkOutput("b2b_first_load", outs(), 6'b010001);
    check_frame("b2b1", 8'h5A);
    begin_frame(8'h81, 1'b1);
    wait_cycle(e_cyc - 1);
    checkOutput("b2b_idle_after_load", outs(), 6'b001000);
    wait_cycle(e_cyc);
    checkOutput("b2b_second_start", outs(), 6'b001001);
    wait_cycle(e_cyc + 96);
    checkOutput("b2b_second_load", outs(), 6'b011001);
    data_read = 1'b1;
    tick();
    checkOutput("read_load_same_cycle", outs(), 6'b001000);
    check_frame("b2b2", 8'h81);

    $display("[TB] reset mid-frame");
    repeat (3) tick();
    begin_frame(8'h0F, 1'b1);
    wait_cycle(e_cyc + 50);
    rst = 1'b1;
    #1;
    checkOutput("midframe_reset", outs(), 6'b000000);
    line_active = 1'b0;
    serial_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (60) tick();
    checkInt("reset_no_more_strobes", strobe_q.size(), 4);
    checkInt("reset_no_load", load_cnt, 0);
    run_clean("post_reset", 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
